// File: rtl/unsig_extend.sv
// Registered zero-extension stage with a valid/ready handshake and a one-entry skid buffer.
// Optional macro UNSIG_EXTEND_SIGN_SEL_EN adds i_sign to select sign extension per operand.
module unsig_extend #(
    parameter int REG_IN_SIZE  = 16,
    parameter int REG_OUT_SIZE = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [REG_IN_SIZE-1:0]  i_reg,
`ifdef UNSIG_EXTEND_SIGN_SEL_EN
    input  logic                    i_sign,
`endif
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [REG_OUT_SIZE-1:0] o_reg,
    output logic                    o_valid,
    input  logic                    i_ready
);

    generate
        if (REG_IN_SIZE < 1 || REG_OUT_SIZE < REG_IN_SIZE) begin : g_bad_params
            $error("unsig_extend: need REG_IN_SIZE >= 1 and REG_OUT_SIZE >= REG_IN_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [REG_OUT_SIZE-1:0] out_q, out_d;
    logic [REG_OUT_SIZE-1:0] skid_q, skid_d;
    logic                    sign_sel;
    logic                    accept;
    logic                    xfer;
    logic [REG_OUT_SIZE-1:0] ext_in;

    // Upper bits are filled with the operand MSB only when sign extension is selected.
    function automatic logic [REG_OUT_SIZE-1:0] extend(input logic [REG_IN_SIZE-1:0] d,
                                                       input logic sgn);
        logic [REG_OUT_SIZE-1:0] r;
        r = {REG_OUT_SIZE{sgn & d[REG_IN_SIZE-1]}};
        r[REG_IN_SIZE-1:0] = d;
        return r;
    endfunction

`ifdef UNSIG_EXTEND_SIGN_SEL_EN
    assign sign_sel = i_sign;
`else
    assign sign_sel = 1'b0;
`endif

    assign ext_in  = extend(i_reg, sign_sel);
    assign accept  = i_valid && (state_q != FULL);
    assign xfer    = (state_q != EMPTY) && i_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    out_d   = ext_in;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    out_d = ext_in;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = ext_in;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_reg   = out_q;
    assign o_valid = (state_q != EMPTY);
    assign o_ready = (state_q != FULL);

endmodule

// File: tb/tb_unsig_extend.sv
// Directed self-checking bench for unsig_extend (default 16 -> 32 configuration).
module tb_unsig_extend;

    logic        i_clk;
    logic        i_reset;
    logic [15:0] i_reg;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_reg;
    logic        o_valid;
    logic        i_ready;
`ifdef UNSIG_EXTEND_SIGN_SEL_EN
    logic        i_sign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    unsig_extend #(.REG_IN_SIZE(16), .REG_OUT_SIZE(32)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_reg   (i_reg),
`ifdef UNSIG_EXTEND_SIGN_SEL_EN
        .i_sign  (i_sign),
`endif
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_reg   (o_reg),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_reg   = 16'h1234;
        i_ready = 1'b0;
        step();
        step();
        i_reset = 1'b0;
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
        n_checks++;
        if (o_reg !== 32'h0) begin n_fail++; $display("FAIL reset_o_reg got %h exp 00000000", o_reg); end
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready got %b exp 1", o_ready); end
    endtask

    // Send a single operand with i_ready high, check the result, then check it drains and holds.
    task automatic test_single(input string name, input logic [15:0] din, input logic [31:0] exp);
        i_ready = 1'b1;
        i_reg   = din;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_reg   = 16'hDEAD;
        n_checks++;
        if (o_reg !== exp || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s got o_reg=%h o_valid=%b exp o_reg=%h o_valid=1", name, o_reg, o_valid, exp);
        end
        step();
        n_checks++;
        if (o_valid !== 1'b0 || o_reg !== exp) begin
            n_fail++;
            $display("FAIL %s_drain got o_reg=%h o_valid=%b exp o_reg=%h o_valid=0", name, o_reg, o_valid, exp);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        i_reg   = 16'h0001;
        i_valid = 1'b1;
        step();
        n_checks++;
        if (o_ready !== 1'b1 || o_reg !== 32'h1 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first got o_ready=%b o_reg=%h o_valid=%b exp 1/00000001/1", o_ready, o_reg, o_valid);
        end
        i_reg = 16'h0002;
        step();
        n_checks++;
        if (o_ready !== 1'b0 || o_reg !== 32'h1) begin
            n_fail++;
            $display("FAIL bp_full got o_ready=%b o_reg=%h exp 0/00000001", o_ready, o_reg);
        end
        i_reg = 16'h0003;
        step();
        n_checks++;
        if (o_ready !== 1'b0 || o_reg !== 32'h1 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold got o_ready=%b o_reg=%h o_valid=%b exp 0/00000001/1", o_ready, o_reg, o_valid);
        end
        i_ready = 1'b1;
        step();
        n_checks++;
        if (o_reg !== 32'h2 || o_valid !== 1'b1 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second got o_reg=%h o_valid=%b o_ready=%b exp 00000002/1/1", o_reg, o_valid, o_ready);
        end
        step();
        i_valid = 1'b0;
        n_checks++;
        if (o_reg !== 32'h3 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_third got o_reg=%h o_valid=%b exp 00000003/1", o_reg, o_valid);
        end
        step();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty got o_valid=%b exp 0", o_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_reg   = 16'h8000 + 16'(k);
            i_valid = 1'b1;
            step();
            exp = 32'h0000_8000 + 32'(k);
            n_checks++;
            if (o_reg !== exp || o_valid !== 1'b1 || o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d got o_reg=%h o_valid=%b o_ready=%b exp %h/1/1", k, o_reg, o_valid, o_ready, exp);
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_midop();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_reg   = 16'hAAAA;
        step();
        i_reg = 16'hBBBB;
        step();
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_full got o_ready=%b exp 0", o_ready);
        end
        i_reset = 1'b1;
        i_ready = 1'b1;
        i_reg   = 16'hCCCC;
        step();
        i_reset = 1'b0;
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_reg !== 32'h0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_after got o_valid=%b o_reg=%h o_ready=%b exp 0/00000000/1", o_valid, o_reg, o_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (o_valid !== 1'b0 || o_reg !== 32'h0) begin
                n_fail++;
                $display("FAIL midrst_stale_%0d got o_valid=%b o_reg=%h exp 0/00000000", k, o_valid, o_reg);
            end
        end
    endtask

`ifdef UNSIG_EXTEND_SIGN_SEL_EN
    task automatic test_sign_sel();
        i_sign = 1'b1;
        test_single("sign_msb", 16'hCAFD, 32'hFFFF_CAFD);
        test_single("sign_pos", 16'h5555, 32'h0000_5555);
        i_sign = 1'b0;
        test_single("nosign_msb", 16'hCAFD, 32'h0000_CAFD);
    endtask
`endif

    initial begin
        i_reset = 1'b1;
        i_reg   = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
`ifdef UNSIG_EXTEND_SIGN_SEL_EN
        i_sign  = 1'b0;
`endif
        test_reset();
        test_single("zero_msb", 16'h5555, 32'h0000_5555);
        test_single("set_msb",  16'hCAFD, 32'h0000_CAFD);
        test_single("all_zero", 16'h0000, 32'h0000_0000);
        test_single("all_ones", 16'hFFFF, 32'h0000_FFFF);
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
`ifdef UNSIG_EXTEND_SIGN_SEL_EN
        test_sign_sel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
